// File: rtl/dlx_pkg.sv
// ---------------------------------------------------------------------------
// dlx_pkg : shared encodings for the DLX decode/issue stage
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package dlx_pkg;

    // opselect codes
    localparam logic [2:0] SHIFT_REG   = 3'b000;
    localparam logic [2:0] ARITH_LOGIC = 3'b001;
    localparam logic [2:0] MEM_WRITE   = 3'b100;
    localparam logic [2:0] MEM_READ    = 3'b101;

    // arithmetic/logic operations
    localparam logic [2:0] ADD  = 3'b000;
    localparam logic [2:0] HADD = 3'b001;
    localparam logic [2:0] SUB  = 3'b010;
    localparam logic [2:0] NOT  = 3'b011;
    localparam logic [2:0] AND  = 3'b100;
    localparam logic [2:0] OR   = 3'b101;
    localparam logic [2:0] XOR  = 3'b110;
    localparam logic [2:0] LHG  = 3'b111;

    // shift operations
    localparam logic [2:0] SHLEFTLOG = 3'b000;
    localparam logic [2:0] SHLEFTART = 3'b001;
    localparam logic [2:0] SHRGHTLOG = 3'b010;
    localparam logic [2:0] SHRGHTART = 3'b011;

    // load formatting operations
    localparam logic [2:0] LOADBYTE  = 3'b000;
    localparam logic [2:0] LOADHALF  = 3'b001;
    localparam logic [2:0] LOADWORD  = 3'b011;
    localparam logic [2:0] LOADBYTEU = 3'b100;
    localparam logic [2:0] LOADHALFU = 3'b101;

    // instruction word field positions (LSB of each field)
    localparam int OPSEL_LSB = 21;
    localparam int OP_LSB    = 18;
    localparam int RD_LSB    = 15;
    localparam int RS1_LSB   = 12;
    localparam int RS2_LSB   = 9;
    localparam int IMM_LSB   = 0;

    // issue FSM encoding
    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_ALU_EXEC = 3'd1;
    localparam logic [2:0] S_ALU_WB   = 3'd2;
    localparam logic [2:0] S_MEM_REQ  = 3'd3;
    localparam logic [2:0] S_MEM_WAIT = 3'd4;

    function automatic logic [15:0] sext_imm9(input logic [8:0] imm);
        return {{7{imm[8]}}, imm};
    endfunction

endpackage

`default_nettype wire

// File: rtl/dlx_regfile.sv
// ---------------------------------------------------------------------------
// dlx_regfile : 16-bit register file, two read ports, debug read, one write
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module dlx_regfile #(
    parameter int NREGS = 8
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        we_i,
    input  logic [2:0]  waddr_i,
    input  logic [15:0] wdata_i,
    input  logic [2:0]  raddr1_i,
    input  logic [2:0]  raddr2_i,
    output logic [15:0] rdata1_o,
    output logic [15:0] rdata2_o,
    input  logic [2:0]  dbg_addr_i,
    output logic [15:0] dbg_data_o
);

    logic [15:0] rf_w [8];

    // r0 and any slot beyond NREGS are constant zero, so writes there vanish
    for (genvar i = 0; i < 8; i++) begin : g_reg
        if (i == 0 || i >= NREGS) begin : g_zero
            assign rf_w[i] = '0;
        end else begin : g_flop
            logic [15:0] reg_q;
            always_ff @(posedge clk_i) begin
                if (!rst_ni) begin
                    reg_q <= '0;
                end else if (we_i && waddr_i == 3'(i)) begin
                    reg_q <= wdata_i;
                end
            end
            assign rf_w[i] = reg_q;
        end
    end

    assign rdata1_o   = rf_w[raddr1_i];
    assign rdata2_o   = rf_w[raddr2_i];
    assign dbg_data_o = rf_w[dbg_addr_i];

endmodule

`default_nettype wire

// File: rtl/dlx_decode_issue.sv
// ---------------------------------------------------------------------------
// dlx_decode_issue : serialised decode/issue stage driving the DLX ALU
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module dlx_decode_issue
    import dlx_pkg::*;
#(
    parameter int ALU_LATENCY = 2,
    parameter int NREGS       = 8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        instr_valid,
    input  logic [23:0] instr_data,
    output logic        instr_ready,
    output logic        enable_arith,
    output logic        enable_shift,
    output logic [2:0]  opselect,
    output logic [2:0]  operation,
    output logic [15:0] aluin1,
    output logic [15:0] aluin2,
    output logic [4:0]  shift_number,
    input  logic [15:0] alu_result,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [15:0] dmem_addr,
    output logic [15:0] dmem_wdata,
    input  logic        dmem_rvalid,
    input  logic [15:0] dmem_rdata,
    output logic        illegal_op,
    input  logic [2:0]  dbg_addr,
    output logic [15:0] dbg_data
);

    localparam int         CNT_W    = 2;
    localparam logic [1:0] CNT_INIT = CNT_W'(ALU_LATENCY - 1);

    logic [2:0]  state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [2:0]  rd_q, rd_d;
    logic        en_arith_q, en_arith_d;
    logic        en_shift_q, en_shift_d;
    logic [2:0]  opsel_q, opsel_d;
    logic [2:0]  op_q, op_d;
    logic [15:0] a1_q, a1_d;
    logic [15:0] a2_q, a2_d;
    logic [4:0]  shamt_q, shamt_d;
    logic        req_q, req_d;
    logic        we_q, we_d;
    logic [15:0] addr_q, addr_d;
    logic [15:0] wdata_q, wdata_d;
    logic        illegal_q, illegal_d;

    logic [2:0]  w_opsel, w_op, w_rd, w_rs1, w_rs2;
    logic [8:0]  w_imm;
    logic [15:0] w_rdata1, w_rdata2, w_eaddr;
    logic        w_legal, w_rf_we;

    assign w_opsel = instr_data[OPSEL_LSB +: 3];
    assign w_op    = instr_data[OP_LSB    +: 3];
    assign w_rd    = instr_data[RD_LSB    +: 3];
    assign w_rs1   = instr_data[RS1_LSB   +: 3];
    assign w_rs2   = instr_data[RS2_LSB   +: 3];
    assign w_imm   = instr_data[IMM_LSB   +: 9];
    assign w_eaddr = w_rdata1 + sext_imm9(w_imm);
    assign w_legal = (w_opsel == SHIFT_REG) || (w_opsel == ARITH_LOGIC) ||
                     (w_opsel == MEM_WRITE) || (w_opsel == MEM_READ);

    dlx_regfile #(
        .NREGS (NREGS)
    ) u_regfile (
        .clk_i      (clock),
        .rst_ni     (reset),
        .we_i       (w_rf_we),
        .waddr_i    (rd_q),
        .wdata_i    (alu_result),
        .raddr1_i   (w_rs1),
        .raddr2_i   (w_rs2),
        .rdata1_o   (w_rdata1),
        .rdata2_o   (w_rdata2),
        .dbg_addr_i (dbg_addr),
        .dbg_data_o (dbg_data)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rd_d       = rd_q;
        en_arith_d = en_arith_q;
        en_shift_d = en_shift_q;
        opsel_d    = opsel_q;
        op_d       = op_q;
        a1_d       = a1_q;
        a2_d       = a2_q;
        shamt_d    = shamt_q;
        req_d      = 1'b0;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        illegal_d  = 1'b0;
        w_rf_we    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (instr_valid) begin
                    // illegal words are consumed without touching any ALU-facing register
                    if (w_legal) begin
                        rd_d    = w_rd;
                        opsel_d = w_opsel;
                        op_d    = w_op;
                        a1_d    = w_rdata1;
                        a2_d    = w_rdata2;
                        shamt_d = w_imm[4:0];
                    end
                    case (w_opsel)
                        SHIFT_REG, ARITH_LOGIC: begin
                            state_d    = S_ALU_EXEC;
                            cnt_d      = CNT_INIT;
                            en_arith_d = (w_opsel == ARITH_LOGIC);
                            en_shift_d = (w_opsel == SHIFT_REG);
                        end
                        MEM_READ, MEM_WRITE: begin
                            state_d = S_MEM_REQ;
                            req_d   = 1'b1;
                            we_d    = (w_opsel == MEM_WRITE);
                            addr_d  = w_eaddr;
                            if (w_opsel == MEM_WRITE) begin
                                wdata_d = w_rdata2;
                            end
                        end
                        default: illegal_d = 1'b1;
                    endcase
                end
            end
            S_ALU_EXEC: begin
                if (cnt_q == '0) begin
                    en_arith_d = 1'b0;
                    en_shift_d = 1'b0;
                    state_d    = S_ALU_WB;
                end else begin
                    cnt_d = cnt_q - 2'd1;
                end
            end
            S_ALU_WB: begin
                w_rf_we = 1'b1;
                state_d = S_IDLE;
            end
            S_MEM_REQ: begin
                state_d = we_q ? S_IDLE : S_MEM_WAIT;
            end
            S_MEM_WAIT: begin
                // load data replaces operand 2 so the ALU can format it
                if (dmem_rvalid) begin
                    a2_d       = dmem_rdata;
                    en_arith_d = 1'b1;
                    cnt_d      = CNT_INIT;
                    state_d    = S_ALU_EXEC;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            rd_q       <= '0;
            en_arith_q <= 1'b0;
            en_shift_q <= 1'b0;
            opsel_q    <= '0;
            op_q       <= '0;
            a1_q       <= '0;
            a2_q       <= '0;
            shamt_q    <= '0;
            req_q      <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            illegal_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rd_q       <= rd_d;
            en_arith_q <= en_arith_d;
            en_shift_q <= en_shift_d;
            opsel_q    <= opsel_d;
            op_q       <= op_d;
            a1_q       <= a1_d;
            a2_q       <= a2_d;
            shamt_q    <= shamt_d;
            req_q      <= req_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            illegal_q  <= illegal_d;
        end
    end

    assign instr_ready  = (state_q == S_IDLE);
    assign enable_arith = en_arith_q;
    assign enable_shift = en_shift_q;
    assign opselect     = opsel_q;
    assign operation    = op_q;
    assign aluin1       = a1_q;
    assign aluin2       = a2_q;
    assign shift_number = shamt_q;
    assign dmem_req     = req_q;
    assign dmem_we      = we_q;
    assign dmem_addr    = addr_q;
    assign dmem_wdata   = wdata_q;
    assign illegal_op   = illegal_q;

endmodule

`default_nettype wire

// File: tb/tb_dlx_decode_issue.sv
// ---------------------------------------------------------------------------
// tb_dlx_decode_issue : directed self-checking bench for dlx_decode_issue
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_dlx_decode_issue;

    localparam logic [2:0] OS_SHIFT = 3'b000;
    localparam logic [2:0] OS_ARITH = 3'b001;
    localparam logic [2:0] OS_STORE = 3'b100;
    localparam logic [2:0] OS_LOAD  = 3'b101;
    localparam logic [2:0] OP_ADD   = 3'b000;
    localparam logic [2:0] OP_SUB   = 3'b010;
    localparam logic [2:0] OP_AND   = 3'b100;
    localparam logic [2:0] OP_OR    = 3'b101;
    localparam logic [2:0] OP_XOR   = 3'b110;
    localparam logic [2:0] OP_SHL   = 3'b000;
    localparam logic [2:0] OP_SHR   = 3'b010;
    localparam logic [2:0] OP_LDW   = 3'b011;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        instr_valid = 1'b0;
    logic [23:0] instr_data = '0;
    logic        instr_ready, enable_arith, enable_shift;
    logic [2:0]  opselect, operation;
    logic [15:0] aluin1, aluin2;
    logic [4:0]  shift_number;
    logic [15:0] alu_result;
    logic        dmem_req, dmem_we;
    logic [15:0] dmem_addr, dmem_wdata;
    logic        dmem_rvalid = 1'b0;
    logic [15:0] dmem_rdata = '0;
    logic        illegal_op;
    logic [2:0]  dbg_addr = '0;
    logic [15:0] dbg_data;

    int checks = 0;
    int errors = 0;
    logic [15:0] exp_rf [8];

    typedef struct {
        logic [23:0] ins;
        logic [15:0] a1;
        logic [15:0] a2;
        logic [4:0]  sh;
        logic        is_sh;
        logic [2:0]  rd;
        logic [15:0] res;
    } vec_t;
    vec_t tbl [6];

    dlx_decode_issue #(.ALU_LATENCY(2), .NREGS(8)) dut (
        .clock        (clock),
        .reset        (reset),
        .instr_valid  (instr_valid),
        .instr_data   (instr_data),
        .instr_ready  (instr_ready),
        .enable_arith (enable_arith),
        .enable_shift (enable_shift),
        .opselect     (opselect),
        .operation    (operation),
        .aluin1       (aluin1),
        .aluin2       (aluin2),
        .shift_number (shift_number),
        .alu_result   (alu_result),
        .dmem_req     (dmem_req),
        .dmem_we      (dmem_we),
        .dmem_addr    (dmem_addr),
        .dmem_wdata   (dmem_wdata),
        .dmem_rvalid  (dmem_rvalid),
        .dmem_rdata   (dmem_rdata),
        .illegal_op   (illegal_op),
        .dbg_addr     (dbg_addr),
        .dbg_data     (dbg_data)
    );

    always #5 clock = ~clock;

    // behavioural stand-in for the downstream ALU
    always_comb begin
        alu_result = '0;
        case (opselect)
            OS_ARITH: case (operation)
                OP_ADD:  alu_result = aluin1 + aluin2;
                OP_SUB:  alu_result = aluin1 - aluin2;
                OP_AND:  alu_result = aluin1 & aluin2;
                OP_OR:   alu_result = aluin1 | aluin2;
                OP_XOR:  alu_result = aluin1 ^ aluin2;
                default: alu_result = '0;
            endcase
            OS_SHIFT: case (operation)
                OP_SHL:  alu_result = aluin1 << shift_number;
                OP_SHR:  alu_result = aluin1 >> shift_number;
                default: alu_result = '0;
            endcase
            OS_LOAD:  alu_result = aluin2;
            default:  alu_result = '0;
        endcase
    end

    function automatic logic [23:0] mk(input logic [2:0] os, input logic [2:0] op,
                                       input logic [2:0] rd, input logic [2:0] rs1,
                                       input logic [2:0] rs2, input logic [8:0] imm);
        return {os, op, rd, rs1, rs2, imm};
    endfunction

    task automatic chk(input string name, input logic [95:0] got, input logic [95:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic issue(input logic [23:0] ins);
        int n = 0;
        instr_valid = 1'b1;
        instr_data  = ins;
        while (!instr_ready && n < 50) begin
            tick();
            n++;
        end
        if (!instr_ready) chk("issue_timeout", 96'(instr_ready), 96'd1);
        tick();
        instr_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (!instr_ready && n < 50) begin
            tick();
            n++;
        end
        chk("idle_reached", 96'(instr_ready), 96'd1);
    endtask

    task automatic check_rf(input string tag);
        for (int i = 0; i < 8; i++) begin
            dbg_addr = 3'(i);
            #1;
            chk($sformatf("%s_r%0d", tag, i), 96'(dbg_data), 96'(exp_rf[i]));
        end
    endtask

    task automatic check_outs_zero(input string tag);
        chk({tag, "_outs"}, {enable_arith, enable_shift, opselect, operation, aluin1, aluin2,
                             shift_number, dmem_req, dmem_we, dmem_addr, dmem_wdata, illegal_op},
            96'd0);
        chk({tag, "_ready"}, 96'(instr_ready), 96'd1);
    endtask

    task automatic load(input logic [2:0] rd, input logic [8:0] imm,
                        input logic [15:0] exp_addr, input logic [15:0] data, input int delay);
        issue(mk(OS_LOAD, OP_LDW, rd, 3'd0, 3'd0, imm));
        chk("load_req", {dmem_req, dmem_we, dmem_addr}, {1'b1, 1'b0, exp_addr});
        repeat (delay) tick();
        dmem_rvalid = 1'b1;
        dmem_rdata  = data;
        tick();
        dmem_rvalid = 1'b0;
        dmem_rdata  = '0;
        wait_idle();
        exp_rf[rd] = (rd == 3'd0) ? 16'h0 : data;
    endtask

    task automatic exec_alu(input string tag, input logic [23:0] ins, input logic [15:0] a1,
                            input logic [15:0] a2, input logic [4:0] sh, input logic is_sh);
        int en_cnt = 0;
        int busy   = 0;
        int bad    = 0;
        issue(ins);
        for (int k = 0; k < 20; k++) begin
            if (instr_ready) break;
            busy++;
            if (enable_arith || enable_shift) begin
                en_cnt++;
                if (enable_shift !== is_sh || enable_arith !== !is_sh) bad++;
                if (aluin1 !== a1 || aluin2 !== a2) bad++;
                if (is_sh && shift_number !== sh) bad++;
            end
            tick();
        end
        chk({tag, "_enable_cycles"}, 96'(en_cnt), 96'd2);
        chk({tag, "_ready_low_cycles"}, 96'(busy), 96'd3);
        chk({tag, "_operand_errs"}, 96'(bad), 96'd0);
    endtask

    task automatic store(input string tag, input logic [23:0] ins,
                         input logic [15:0] exp_addr, input logic [15:0] exp_wdata);
        int reqs = 0;
        int ens  = 0;
        logic [32:0] seen = '0;
        issue(ins);
        for (int k = 0; k < 6; k++) begin
            if (dmem_req) begin
                reqs++;
                seen = {dmem_we, dmem_addr, dmem_wdata};
            end
            if (enable_arith || enable_shift) ens++;
            tick();
        end
        chk({tag, "_req_count"}, 96'(reqs), 96'd1);
        chk({tag, "_we_addr_wdata"}, 96'(seen), 96'({1'b1, exp_addr, exp_wdata}));
        chk({tag, "_no_enable"}, 96'(ens), 96'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 8; i++) exp_rf[i] = '0;

        tbl[0] = '{mk(OS_SHIFT, OP_SHL, 3'd5, 3'd1, 3'd0, 9'd3), 16'h0008, 16'h0000, 5'd3, 1'b1, 3'd5, 16'h0040};
        tbl[1] = '{mk(OS_ARITH, OP_ADD, 3'd4, 3'd1, 3'd5, 9'd0), 16'h0008, 16'h0040, 5'd0, 1'b0, 3'd4, 16'h0048};
        tbl[2] = '{mk(OS_ARITH, OP_SUB, 3'd6, 3'd5, 3'd1, 9'd0), 16'h0040, 16'h0008, 5'd0, 1'b0, 3'd6, 16'h0038};
        tbl[3] = '{mk(OS_ARITH, OP_XOR, 3'd7, 3'd4, 3'd6, 9'd0), 16'h0048, 16'h0038, 5'd0, 1'b0, 3'd7, 16'h0070};
        tbl[4] = '{mk(OS_ARITH, OP_ADD, 3'd0, 3'd1, 3'd5, 9'd0), 16'h0008, 16'h0040, 5'd0, 1'b0, 3'd0, 16'h0000};
        tbl[5] = '{mk(OS_SHIFT, OP_SHR, 3'd7, 3'd5, 3'd0, 9'd2), 16'h0040, 16'h0000, 5'd2, 1'b1, 3'd7, 16'h0010};

        reset = 1'b0;
        repeat (2) tick();
        check_outs_zero("por");
        reset = 1'b1;
        tick();

        load(3'd6, 9'h010, 16'h0010, 16'h1234, 2);
        check_rf("preload");

        // reset while a load waits for data
        issue(mk(OS_LOAD, OP_LDW, 3'd4, 3'd0, 3'd0, 9'h020));
        tick();
        tick();
        reset = 1'b0;
        tick();
        check_outs_zero("midwait_rst");
        reset = 1'b1;
        dmem_rvalid = 1'b1;
        dmem_rdata  = 16'hBEEF;
        tick();
        dmem_rvalid = 1'b0;
        repeat (4) tick();
        chk("post_rst_idle", {instr_ready, enable_arith, dmem_req}, {1'b1, 1'b0, 1'b0});
        for (int i = 0; i < 8; i++) exp_rf[i] = '0;
        check_rf("post_rst");

        load(3'd2, 9'h004, 16'h0004, 16'h0005, 1);
        load(3'd3, 9'h006, 16'h0006, 16'h0003, 3);
        exec_alu("add_r1", mk(OS_ARITH, OP_ADD, 3'd1, 3'd2, 3'd3, 9'd0), 16'h0005, 16'h0003, 5'd0, 1'b0);
        exp_rf[1] = 16'h0008;
        check_rf("after_add");

        for (int v = 0; v < 6; v++) begin
            exec_alu($sformatf("vec%0d", v), tbl[v].ins, tbl[v].a1, tbl[v].a2, tbl[v].sh, tbl[v].is_sh);
            if (tbl[v].rd != 3'd0) exp_rf[tbl[v].rd] = tbl[v].res;
            dbg_addr = tbl[v].rd;
            #1;
            chk($sformatf("vec%0d_rd", v), 96'(dbg_data), 96'(tbl[v].res));
        end

        store("st_neg", mk(OS_STORE, 3'd0, 3'd0, 3'd1, 3'd5, 9'h1FF), 16'h0007, 16'h0040);
        check_rf("after_store");

        // illegal opselect, valid held and next word presented straight after
        instr_valid = 1'b1;
        instr_data  = mk(3'b010, 3'd0, 3'd2, 3'd1, 3'd1, 9'd0);
        tick();
        chk("illegal_pulse", {illegal_op, instr_ready}, {1'b1, 1'b1});
        instr_data = mk(OS_ARITH, OP_ADD, 3'd3, 3'd1, 3'd1, 9'd0);
        tick();
        instr_valid = 1'b0;
        chk("illegal_then_accept", {illegal_op, instr_ready, enable_arith}, {1'b0, 1'b0, 1'b1});
        wait_idle();
        exp_rf[3] = 16'h0010;
        check_rf("after_illegal");

        load(3'd1, 9'h030, 16'h0030, 16'hFFFF, 1);
        store("st_wrap", mk(OS_STORE, 3'd0, 3'd0, 3'd1, 3'd2, 9'h002), 16'h0001, 16'h0005);
        check_rf("final");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
